// File: rtl/tank_spawn_ctrl.sv
// Enemy tank spawn scheduler: staggered start, per-slot respawn countdown,
// cap on simultaneously active slots, and a finite wave with kill accounting.
module tank_spawn_ctrl #(
    parameter int N_TANKS       = 4,
    parameter int RESPAWN_TICKS = 8,
    parameter int MAX_ALIVE     = 3,
    parameter int WAVE_SIZE     = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               tick,
    input  logic [N_TANKS-1:0] tank_state,
    output logic [N_TANKS-1:0] tank_en,
    output logic [4:0]         alive_cnt,
    output logic [7:0]         kill_cnt,
    output logic [7:0]         spawn_cnt,
    output logic               spawn_pulse,
    output logic [3:0]         spawn_idx,
    output logic               wave_done
);

    typedef enum logic [1:0] {G_IDLE, G_RUN, G_DONE} g_state_t;
    typedef enum logic [1:0] {S_OFF, S_WAIT, S_ACTIVE} s_state_t;

    localparam logic [7:0] RESP_C = 8'(RESPAWN_TICKS);
    localparam logic [7:0] WAVE_C = 8'(WAVE_SIZE);
    localparam logic [4:0] MAX_C  = 5'(MAX_ALIVE);

    g_state_t           g_state;
    g_state_t           g_state_nx;
    s_state_t           slot_st [N_TANKS];
    s_state_t           slot_nx [N_TANKS];
    logic [7:0]         cnt     [N_TANKS];
    logic [7:0]         cnt_nx  [N_TANKS];
    logic [N_TANKS-1:0] ts_q;
    logic [N_TANKS-1:0] kill_vec;
    logic [N_TANKS-1:0] en_nx;
    logic [4:0]         alive_nx;
    logic [8:0]         kill_sum;
    logic [7:0]         kill_nx;
    logic [7:0]         spawn_nx;
    logic               found;
    logic [3:0]         spawn_sel;
    logic               spawn_go;
    logic               wave_start;
    logic               wave_end;

    function automatic logic [7:0] sat_u8(input logic [8:0] v);
        return v[8] ? 8'hFF : v[7:0];
    endfunction

    function automatic logic [7:0] dec_sat(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_state <= G_IDLE;
        end else begin
            g_state <= g_state_nx;
        end
    end

    always_comb begin
        g_state_nx = g_state;
        if (!run) begin
            g_state_nx = G_IDLE;
        end else begin
            case (g_state)
                G_IDLE:  g_state_nx = G_RUN;
                G_RUN:   if (spawn_cnt == WAVE_C && alive_cnt == 5'd0) g_state_nx = G_DONE;
                G_DONE:  g_state_nx = G_DONE;
                default: g_state_nx = G_IDLE;
            endcase
        end
    end

    always_comb begin
        wave_start = (g_state == G_IDLE) && run;
        wave_end   = (g_state == G_RUN) && run && (spawn_cnt == WAVE_C) && (alive_cnt == 5'd0);

        // Lowest-index waiting slot whose countdown (pre-decrement) has expired
        found     = 1'b0;
        spawn_sel = 4'd0;
        for (int i = 0; i < N_TANKS; i++) begin
            if (!found && slot_st[i] == S_WAIT && cnt[i] == 8'd0) begin
                found     = 1'b1;
                spawn_sel = 4'(i);
            end
        end
        spawn_go = (g_state == G_RUN) && run && tick && found &&
                   (alive_cnt < MAX_C) && (spawn_cnt < WAVE_C);

        kill_vec = '0;
        kill_sum = {1'b0, kill_cnt};
        for (int i = 0; i < N_TANKS; i++) begin
            kill_vec[i] = run && (g_state != G_IDLE) && (slot_st[i] == S_ACTIVE) &&
                          ts_q[i] && !tank_state[i];
            kill_sum    = kill_sum + 9'(kill_vec[i]);
        end

        en_nx    = '0;
        alive_nx = 5'd0;
        for (int i = 0; i < N_TANKS; i++) begin
            slot_nx[i] = slot_st[i];
            cnt_nx[i]  = cnt[i];
            if (!run) begin
                slot_nx[i] = S_OFF;
                cnt_nx[i]  = 8'd0;
            end else if (wave_start) begin
                slot_nx[i] = S_WAIT;
                cnt_nx[i]  = 8'(i);
            end else if (kill_vec[i]) begin
                slot_nx[i] = S_WAIT;
                cnt_nx[i]  = RESP_C;
            end else if (slot_st[i] == S_WAIT && g_state == G_RUN) begin
                if (tick) cnt_nx[i] = dec_sat(cnt[i]);
                if (spawn_go && spawn_sel == 4'(i)) slot_nx[i] = S_ACTIVE;
            end
            en_nx[i] = (slot_nx[i] == S_ACTIVE);
            alive_nx = alive_nx + 5'(en_nx[i]);
        end

        kill_nx  = wave_start ? 8'd0 : sat_u8(kill_sum);
        spawn_nx = wave_start ? 8'd0 : (spawn_go ? spawn_cnt + 8'd1 : spawn_cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q        <= '0;
            tank_en     <= '0;
            alive_cnt   <= 5'd0;
            kill_cnt    <= 8'd0;
            spawn_cnt   <= 8'd0;
            spawn_pulse <= 1'b0;
            spawn_idx   <= 4'd0;
            wave_done   <= 1'b0;
            for (int i = 0; i < N_TANKS; i++) begin
                slot_st[i] <= S_OFF;
                cnt[i]     <= 8'd0;
            end
        end else begin
            ts_q        <= tank_state;
            tank_en     <= en_nx;
            alive_cnt   <= alive_nx;
            kill_cnt    <= kill_nx;
            spawn_cnt   <= spawn_nx;
            spawn_pulse <= spawn_go;
            if (spawn_go) spawn_idx <= spawn_sel;
            // Sticky until the next wave starts; held through run=0 for display
            if (wave_start)    wave_done <= 1'b0;
            else if (wave_end) wave_done <= 1'b1;
            for (int i = 0; i < N_TANKS; i++) begin
                slot_st[i] <= slot_nx[i];
                cnt[i]     <= cnt_nx[i];
            end
        end
    end

endmodule

// File: tb/tb_tank_spawn_ctrl.sv
// Directed bench for tank_spawn_ctrl with default parameters (4 slots, respawn 8,
// cap 3, wave 10); expected values are worked out by hand.
module tb_tank_spawn_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       tick;
    logic [3:0] tank_state;
    logic [3:0] tank_en;
    logic [4:0] alive_cnt;
    logic [7:0] kill_cnt;
    logic [7:0] spawn_cnt;
    logic       spawn_pulse;
    logic [3:0] spawn_idx;
    logic       wave_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tank_spawn_ctrl #(
        .N_TANKS(4), .RESPAWN_TICKS(8), .MAX_ALIVE(3), .WAVE_SIZE(10)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .tick(tick), .tank_state(tank_state),
        .tank_en(tank_en), .alive_cnt(alive_cnt), .kill_cnt(kill_cnt),
        .spawn_cnt(spawn_cnt), .spawn_pulse(spawn_pulse), .spawn_idx(spawn_idx),
        .wave_done(wave_done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given tick level; returns 1 time unit after the edge
    task automatic cyc(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    initial begin
        int npulse;
        int tot;
        bit done_chk;

        rst = 1'b1; run = 1'b0; tick = 1'b0; tank_state = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_tank_en", tank_en, 0);
        check_val("rst_alive", alive_cnt, 0);
        check_val("rst_kill", kill_cnt, 0);
        check_val("rst_spawn", spawn_cnt, 0);
        check_val("rst_pulse", spawn_pulse, 0);
        check_val("rst_idx", spawn_idx, 0);
        check_val("rst_done", wave_done, 0);
        rst = 1'b0;
        cyc(0);

        // Wave 1: staggered start, cap at three alive
        run = 1'b1;
        cyc(0);
        check_val("w1_start_en", tank_en, 0);
        cyc(1);
        check_val("w1_t1_pulse", spawn_pulse, 1);
        check_val("w1_t1_idx", spawn_idx, 0);
        check_val("w1_t1_en", tank_en, 4'b0001);
        cyc(0);
        check_val("w1_pulse_one_cycle", spawn_pulse, 0);
        check_val("w1_idx_held", spawn_idx, 0);
        cyc(1);
        check_val("w1_t2_idx", spawn_idx, 1);
        check_val("w1_t2_en", tank_en, 4'b0011);
        cyc(0);
        cyc(1);
        check_val("w1_t3_idx", spawn_idx, 2);
        check_val("w1_t3_en", tank_en, 4'b0111);
        check_val("w1_t3_alive", alive_cnt, 3);
        cyc(0);
        cyc(1);
        check_val("w1_t4_capped_pulse", spawn_pulse, 0);
        check_val("w1_t4_en", tank_en, 4'b0111);
        check_val("w1_t4_spawn", spawn_cnt, 3);

        tank_state = 4'b0111;
        cyc(0);
        tank_state = 4'b0101;
        cyc(0);
        check_val("w1_kill1_en", tank_en, 4'b0101);
        check_val("w1_kill1_cnt", kill_cnt, 1);
        check_val("w1_kill1_alive", alive_cnt, 2);
        cyc(1);
        check_val("w1_t5_pulse", spawn_pulse, 1);
        check_val("w1_t5_idx", spawn_idx, 3);
        check_val("w1_t5_en", tank_en, 4'b1101);
        check_val("w1_t5_spawn", spawn_cnt, 4);

        tank_state = 4'b1101;
        cyc(0);
        tank_state = 4'b1100;
        cyc(0);
        check_val("w1_kill0_en", tank_en, 4'b1100);
        check_val("w1_kill0_alive", alive_cnt, 2);
        check_val("w1_kill0_cnt", kill_cnt, 2);

        // Ticks 2..8 after slot 1's kill: nothing is eligible yet
        npulse = 0;
        for (int k = 2; k <= 8; k++) begin
            cyc(1);
            npulse += int'(spawn_pulse);
            cyc(0);
        end
        check_val("w1_no_early_respawn", npulse, 0);
        cyc(1);
        check_val("w1_9th_pulse", spawn_pulse, 1);
        check_val("w1_9th_idx", spawn_idx, 1);
        check_val("w1_9th_en", tank_en, 4'b1110);
        check_val("w1_9th_spawn", spawn_cnt, 5);

        tank_state = 4'b1000;
        cyc(0);
        check_val("w1_kill2_en", tank_en, 4'b1010);
        check_val("w1_kill2_alive", alive_cnt, 2);

        run = 1'b0;
        cyc(0);
        check_val("abort_en", tank_en, 0);
        check_val("abort_alive", alive_cnt, 0);
        check_val("abort_kill_held", kill_cnt, 3);
        check_val("abort_spawn_held", spawn_cnt, 5);
        tank_state = 4'b0000;
        cyc(0);
        cyc(0);

        // Wave 2: restart, simultaneous kill+spawn, then run to completion
        run = 1'b1;
        cyc(0);
        check_val("w2_kill_clr", kill_cnt, 0);
        check_val("w2_spawn_clr", spawn_cnt, 0);
        check_val("w2_done_clr", wave_done, 0);
        cyc(1);
        check_val("w2_t1_idx", spawn_idx, 0);
        check_val("w2_t1_pulse", spawn_pulse, 1);
        cyc(1);
        check_val("w2_t2_idx", spawn_idx, 1);
        cyc(1);
        check_val("w2_t3_en", tank_en, 4'b0111);
        tank_state = 4'b0111;
        cyc(0);
        tank_state = 4'b0101;
        cyc(0);
        check_val("w2_kill1_alive", alive_cnt, 2);
        tank_state = 4'b0100;
        cyc(1);
        check_val("w2_sim_pulse", spawn_pulse, 1);
        check_val("w2_sim_idx", spawn_idx, 3);
        check_val("w2_sim_en", tank_en, 4'b1100);
        check_val("w2_sim_alive", alive_cnt, 2);
        check_val("w2_sim_kill", kill_cnt, 2);
        check_val("w2_sim_spawn", spawn_cnt, 4);

        tot = 4;
        done_chk = 1'b0;
        for (int it = 0; it < 40; it++) begin
            cyc(1);
            if (spawn_pulse) tot++;
            tank_state = tank_en;
            cyc(0);
            tank_state = 4'b0000;
            cyc(0);
            if (tot == 10 && !done_chk) begin
                check_val("w2_last_kill_alive", alive_cnt, 0);
                check_val("w2_done_not_yet", wave_done, 0);
                cyc(0);
                check_val("w2_done_next_cycle", wave_done, 1);
                done_chk = 1'b1;
            end else begin
                cyc(0);
            end
        end
        check_val("w2_done_reached", done_chk, 1);
        check_val("w2_total_pulses", tot, 10);
        check_val("w2_spawn_final", spawn_cnt, 10);
        check_val("w2_kill_final", kill_cnt, 10);
        check_val("w2_done_sticky", wave_done, 1);
        check_val("w2_en_final", tank_en, 0);

        run = 1'b0;
        cyc(0);
        check_val("w2_stop_done_held", wave_done, 1);
        check_val("w2_stop_kill_held", kill_cnt, 10);

        // Wave 3: three alive, then asynchronous reset between clock edges
        run = 1'b1;
        cyc(0);
        check_val("w3_done_clr", wave_done, 0);
        check_val("w3_spawn_clr", spawn_cnt, 0);
        cyc(1);
        cyc(1);
        cyc(1);
        tank_state = 4'b0111;
        cyc(0);
        tank_state = 4'b0011;
        cyc(0);
        check_val("w3_kill_cnt", kill_cnt, 1);
        cyc(1);
        check_val("w3_en_before_rst", tank_en, 4'b1011);
        check_val("w3_alive_before_rst", alive_cnt, 3);

        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("async_rst_en", tank_en, 0);
        check_val("async_rst_alive", alive_cnt, 0);
        check_val("async_rst_kill", kill_cnt, 0);
        check_val("async_rst_spawn", spawn_cnt, 0);
        check_val("async_rst_done", wave_done, 0);
        run = 1'b0;
        tank_state = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        cyc(0);
        cyc(1);
        check_val("idle_no_spawn", tank_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tank_spawn_ctrl.md
Name: tank_spawn_ctrl

Overview:
Parametrised enemy-tank spawn scheduler. It generalises the fixed four-tank generator to N_TANKS slots, adding:
- per-slot respawn countdown,
- a global cap on simultaneously alive tanks,
- a finite wave with kill accounting and a wave-done flag.

It sits between game_mode (run) and the enytank_app instances: it drives each instance's tank_en and watches each instance's tank_state.

Parameters:
N_TANKS, 4, number of enemy slots (1..16)
RESPAWN_TICKS, 8, ticks a killed slot waits before it is eligible again (1..255)
MAX_ALIVE, 3, maximum slots ACTIVE at once (1..N_TANKS)
WAVE_SIZE, 10, total spawns allowed per wave (1..255)

Ports:
clk  in  1  system clock (100 MHz domain)
rst  in  1  asynchronous, active-high reset
run  in  1  game running level from game_mode; low = stop/abort wave
tick  in  1  single-cycle spawn-rate strobe (4 Hz), synchronous to clk
tank_state  in  N_TANKS  per-slot alive flag from enytank_app
tank_en  out  N_TANKS  per-slot enable to enytank_app (registered)
alive_cnt  out  5  number of ACTIVE slots
kill_cnt  out  8  kills in current wave, saturates at 255
spawn_cnt  out  8  spawns in current wave
spawn_pulse  out  1  one-cycle pulse when a slot is spawned
spawn_idx  out  4  index of slot spawned (valid with spawn_pulse; held otherwise)
wave_done  out  1  sticky: wave finished

Behaviour:
- Reset (async, rst=1):
  - global FSM = G_IDLE; all slots = S_OFF with counters 0.
  - All outputs 0: tank_en, alive_cnt, kill_cnt, spawn_cnt, spawn_pulse, spawn_idx, wave_done.
  - tank_state history register = 0.
- Global FSM: G_IDLE -> G_RUN -> G_DONE.
  - G_IDLE -> G_RUN: on a cycle with run=1. That cycle clears kill_cnt, spawn_cnt and wave_done, and puts every slot i into S_WAIT with cnt_i = i (staggered start).
  - G_RUN -> G_DONE: when spawn_cnt==WAVE_SIZE and alive_cnt==0. wave_done goes to 1 on the following cycle.
  - Any state with run=0: goes to G_IDLE next cycle, all slots S_OFF, tank_en all 0, counters cleared. kill_cnt, spawn_cnt and wave_done are held for display.
  - G_DONE stays until run=0.
- Slot FSM (per slot i), states S_OFF, S_WAIT, S_ACTIVE.
  - S_WAIT, on tick: cnt_i decrements, saturating at 0. The spawn eligibility check uses the pre-decrement value.
  - Spawn (only on a tick cycle in G_RUN), all of the following must hold:
    - the slot is the lowest-index S_WAIT slot with cnt_i==0;
    - alive_cnt < MAX_ALIVE;
    - spawn_cnt < WAVE_SIZE.
  - Effect of a spawn: that slot -> S_ACTIVE, tank_en[i]=1 next cycle, spawn_pulse=1 and spawn_idx=i for one cycle, spawn_cnt+1.
  - At most one spawn per tick. A blocked eligible slot stays S_WAIT with cnt 0 and retries on the next tick.
  - S_ACTIVE: a kill is a falling edge of tank_state[i], i.e. the registered previous value is 1 and the current value is 0.
  - Effect of a kill: slot -> S_WAIT, cnt_i = RESPAWN_TICKS, tank_en[i]=0 next cycle, kill_cnt+1 (saturating).
  - Once spawn_cnt==WAVE_SIZE, killed slots still go to S_WAIT but never spawn again.
- Simultaneous kill and spawn in the same cycle:
  - The killed slot cannot be the spawned slot (its cnt was nonzero or it was ACTIVE).
  - alive_cnt is net unchanged.
  - The spawn cap check uses the pre-update alive_cnt.
  - Multiple kills in one cycle are all counted.
- alive_cnt is registered and equals the popcount of S_ACTIVE slots after the update. Latency from a tick to tank_en rising is 1 cycle.
- tank_state edges are ignored in S_OFF and S_WAIT.
- An asynchronous rst mid-wave returns to the reset state immediately.

Test Plan:
- Reset mid-wave with 3 tanks active -> tank_en=0000, alive_cnt=0, kill_cnt=0, wave_done=0 immediately, without waiting for a clock edge.
- run=1 then 4 ticks (defaults) -> spawns on ticks 1, 2, 3 at idx 0, 1, 2. Tick 4 is blocked (alive=3=MAX_ALIVE) and tank_en stays 0111. spawn_cnt=3.
- Slot 1 tank_state 1->0 -> tank_en=0101, kill_cnt=1, alive=2. The next tick spawns idx 3 (tank_en=1101). Slot 1 respawns exactly on the 9th tick after the kill, if not capped.
- Kill on slot 0 in the same cycle as a tick spawns slot 3 -> kill_cnt+1, spawn_cnt+1, alive_cnt unchanged.
- Full wave (WAVE_SIZE=10): kill every spawned tank -> spawn_cnt stops at 10, no 11th spawn_pulse. wave_done=1 one cycle after the last kill and stays 1 while run=1.
- run dropped mid-wave with 2 alive -> next cycle tank_en=0, alive=0, kill_cnt held. Raising run again clears kill_cnt and spawn_cnt and restarts the stagger.
